// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state codes and bit-timing defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // 100 MHz core clock / 115200 baud
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

    typedef logic [2:0] uart_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Countdown reload: a timer loaded with this value expires after 'cycles' clocks.
    function automatic logic [15:0] timer_reload(input int unsigned cycles);
        return 16'(cycles - 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible at pop_dat the cycle after it is written into an empty FIFO.
// Backpressure: push is accepted when not full or when a pop happens in the same cycle; otherwise ignored.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_dat,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (DEPTH_LOG2 + 1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign push_ok = push && (!full || pop_ok);
    assign count   = cnt;
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT byte FIFO, with sticky frame/overrun flags.
// Latency: byte pushed on the stop-bit sample, rx_valid rises the following cycle.
// Backpressure: rx_valid/rx_ready handshake; a byte arriving while full with no pop is dropped and flags overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  UART_RX,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [7:0]            rx_data,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  err_clr
);

    localparam logic [15:0] HALF_RELOAD = timer_reload(CLKS_PER_BIT / 2);
    localparam logic [15:0] BIT_RELOAD  = timer_reload(CLKS_PER_BIT);

    logic        rx_meta;
    logic        rx_sync;
    uart_state_t state;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    logic        timer_exp;
    logic        stop_sample;
    logic        push;
    logic        frame_evt;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_sync <= rx_meta;
        end
    end

    assign timer_exp   = (timer == '0);
    assign stop_sample = (state == ST_STOP) && timer_exp;
    assign push        = stop_sample && rx_sync;
    assign frame_evt   = stop_sample && !rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state <= ST_START;
                        timer <= HALF_RELOAD;
                    end
                end
                ST_START: begin
                    if (!timer_exp) begin
                        timer <= timer - 1'b1;
                    end else if (rx_sync) begin
                        state <= ST_IDLE;
                    end else begin
                        state   <= ST_DATA;
                        timer   <= BIT_RELOAD;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (!timer_exp) begin
                        timer <= timer - 1'b1;
                    end else begin
                        shift   <= {rx_sync, shift[7:1]};
                        timer   <= BIT_RELOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!timer_exp) begin
                        timer <= timer - 1'b1;
                    end else begin
                        state <= rx_sync ? ST_IDLE : ST_BREAK;
                    end
                end
                // Line held low past the stop bit: wait for it to return high
                // so a long break is not mistaken for a run of start bits.
                ST_BREAK: begin
                    if (rx_sync) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;
    assign drop     = push && fifo_full && !pop;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (shift),
        .pop      (pop),
        .pop_dat  (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (rx_count)
    );

    // Clear is applied first so a coincident new error keeps its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (frame_evt) begin
                frame_err <= 1'b1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at CLKS_PER_BIT=16, DEPTH_LOG2=4.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    // Stop-bit sample edge counted from the frame's first driven cycle:
    // 2 sync flops + 1 idle detect + CPB/2 + 9*CPB, minus one for the drive/sample offset.
    localparam int STOP_CYC = 2 + 1 + CPB / 2 + 9 * CPB - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_line;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic [DL:0]   rx_count;
    logic          frame_err;
    logic          overrun;
    logic          err_clr;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            vld_cnt = 0;
    int            v0;
    logic          ov_exp;
    logic [7:0]    rb;
    logic [7:0]    got_q[$];
    logic [7:0]    exp_got[$];
    logic [7:0]    fifo_m[$];

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (DL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .UART_RX   (uart_line),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            vld_cnt++;
            if (rx_ready) got_q.push_back(rx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag);
        chk({tag, "_len"}, got_q.size(), exp_got.size());
        for (int i = 0; i < exp_got.size() && i < got_q.size(); i++)
            chk(tag, {24'd0, got_q[i]}, {24'd0, exp_got[i]});
        got_q.delete();
        exp_got.delete();
    endtask

    // A correctly framed byte goes straight to the consumer if it is ready,
    // otherwise into the FIFO, or is lost with overrun when 16 are held.
    task automatic model_good(input logic [7:0] b);
        if (rx_ready) exp_got.push_back(b);
        else if (fifo_m.size() < DEPTH) fifo_m.push_back(b);
        else ov_exp = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_lvl,
                              input int ready_cyc, input int err_cyc, input int rst_cyc);
        int total;
        total = 9 * CPB + stop_len;
        for (int c = 0; c < total; c++) begin
            if (c < CPB) uart_line = 1'b0;
            else if (c < 9 * CPB) uart_line = b[3'((c / CPB) - 1)];
            else uart_line = stop_lvl;
            if (ready_cyc >= 0) rx_ready = (c == ready_cyc);
            if (err_cyc >= 0) err_clr = (c == err_cyc);
            if (rst_cyc >= 0) rst = (c >= rst_cyc) && (c < rst_cyc + 4);
            tick();
        end
        uart_line = 1'b1;
        err_clr   = 1'b0;
        if (rst_cyc >= 0) rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, CPB, 1'b1, -1, -1, -1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            tick();
            if (!rx_valid) done = 1'b1;
        end
        rx_ready = 1'b0;
        chk("drain_done", {31'd0, done}, 32'd1);
        while (fifo_m.size() > 0) exp_got.push_back(fifo_m.pop_front());
        chk_q("drain_order");
    endtask

    initial begin
        rst       = 1'b1;
        uart_line = 1'b1;
        rx_ready  = 1'b0;
        err_clr   = 1'b0;
        ov_exp    = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_count", {27'd0, rx_count}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

        // single byte, consumer always ready
        rx_ready = 1'b1;
        v0 = vld_cnt;
        send_byte(8'hA5);
        model_good(8'hA5);
        chk("a5_valid_cycles", vld_cnt - v0, 32'd1);
        chk_q("a5_data");
        chk("a5_frame_err", {31'd0, frame_err}, 32'd0);
        chk("a5_count", {27'd0, rx_count}, 32'd0);

        // short low glitch is rejected
        v0 = vld_cnt;
        uart_line = 1'b0;
        repeat (4) tick();
        uart_line = 1'b1;
        repeat (30) tick();
        chk("glitch_valid_cycles", vld_cnt - v0, 32'd0);
        chk("glitch_count", {27'd0, rx_count}, 32'd0);
        rb = 8'($urandom);
        send_byte(rb);
        model_good(rb);
        chk_q("post_glitch");

        // random stream, ready consumer
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            send_byte(rb);
            model_good(rb);
        end
        chk_q("rand_stream");

        // random bytes held, then drained
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            send_byte(rb);
            model_good(rb);
        end
        chk("held_count", {27'd0, rx_count}, fifo_m.size());
        chk("held_valid", {31'd0, rx_valid}, 32'd1);
        chk("held_head", {24'd0, rx_data}, {24'd0, fifo_m[0]});
        drain();

        // framing error with long break, then recovery
        rx_ready = 1'b1;
        send_frame(8'h3C, 40, 1'b0, -1, -1, -1);
        chk("break_frame_err", {31'd0, frame_err}, 32'd1);
        chk("break_count", {27'd0, rx_count}, 32'd0);
        chk_q("break_nothing");
        send_byte(8'h55);
        model_good(8'h55);
        chk_q("after_break");
        chk("frame_err_sticky", {31'd0, frame_err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("frame_err_cleared", {31'd0, frame_err}, 32'd0);

        // overflow: 17 bytes into 16 slots, err_clr coincident with the drop
        rx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            model_good(8'(i));
        end
        send_frame(8'h10, CPB, 1'b1, -1, STOP_CYC, -1);
        model_good(8'h10);
        chk("ovf_count", {27'd0, rx_count}, 32'd16);
        chk("ovf_overrun", {31'd0, overrun}, {31'd0, ov_exp});
        chk("ovf_frame_err", {31'd0, frame_err}, 32'd0);
        drain();
        chk("ovf_drained_count", {27'd0, rx_count}, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        ov_exp  = 1'b0;
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);

        // full FIFO with pop on the push cycle
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom);
            send_byte(rb);
            model_good(rb);
        end
        chk("full_count", {27'd0, rx_count}, 32'd16);
        send_frame(8'h77, CPB, 1'b1, STOP_CYC, -1, -1);
        exp_got.push_back(fifo_m.pop_front());
        fifo_m.push_back(8'h77);
        chk("pushpop_count", {27'd0, rx_count}, 32'd16);
        chk("pushpop_overrun", {31'd0, overrun}, 32'd0);
        chk_q("pushpop_popped");
        drain();

        // reset in the middle of a frame
        rx_ready = 1'b1;
        v0 = vld_cnt;
        send_frame(8'hFF, CPB, 1'b1, -1, -1, 5 * CPB);
        chk("midrst_count", {27'd0, rx_count}, 32'd0);
        chk("midrst_valid_cycles", vld_cnt - v0, 32'd0);
        chk_q("midrst_nothing");
        send_byte(8'h81);
        model_good(8'h81);
        chk_q("after_midrst");
        chk("final_frame_err", {31'd0, frame_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, log2 of receive FIFO depth (16 entries).
REQ-003 SHALL have port clk  input  1  system clock; one clock domain. Reset is synchronous and active-high.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port UART_RX  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_valid  output  1  FIFO non-empty; rx_data holds the oldest byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts head byte when rx_valid & rx_ready.
REQ-008 SHALL have port rx_data  output  8  head-of-FIFO byte, first-word-fall-through.
REQ-009 SHALL have port rx_count  output  DEPTH_LOG2+1  number of bytes held.
REQ-010 SHALL have port frame_err  output  1  sticky; stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  sticky; byte dropped because FIFO full.
REQ-012 SHALL have port err_clr  input  1  clears frame_err and overrun on the next edge.

Function
REQ-013 SHALL pass UART_RX through a 2-flop synchronizer reset to 1; all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK with a bit-timer counter and 3-bit bit index.
REQ-015 IDLE: synchronized line low -> START, timer loaded for CLKS_PER_BIT/2 (integer floor) cycles.
REQ-016 START: at timer expiry, line high -> IDLE (glitch rejected, nothing pushed); line low -> DATA, timer = CLKS_PER_BIT.
REQ-017 DATA: each timer expiry samples one bit into shift register LSB first; after bit index 7 -> STOP, timer = CLKS_PER_BIT.
REQ-018 STOP: at expiry, line high -> push byte, go IDLE; line low -> set frame_err, discard byte, go BREAK.
REQ-019 BREAK: remain until synchronized line high, then IDLE; no start detection while in BREAK.
REQ-020 Push occurs on the stop-sample cycle; rx_valid SHALL be high on the following cycle when FIFO was empty.
REQ-021 Pop occurs when rx_valid & rx_ready; rx_data SHALL show the next byte the cycle after pop.
REQ-022 Push while full without simultaneous pop SHALL drop the new byte, keep contents, set overrun.
REQ-023 Push and pop in the same cycle SHALL both succeed at any fill level including full; rx_count unchanged.
REQ-024 rx_ready with FIFO empty SHALL have no effect; pointers wrap modulo 2^DEPTH_LOG2.
REQ-025 err_clr coincident with a new error event SHALL leave the flag set (set wins).

Reset
REQ-026 On rst: state IDLE, timer 0, bit index 0, shift register 0, synchronizer flops 1.
REQ-027 On rst: FIFO pointers 0, rx_valid 0, rx_count 0, frame_err 0, overrun 0; rx_data 0 when empty.
REQ-028 Reset mid-frame SHALL abandon the frame; the partial byte is never pushed; reception restarts on the next falling edge after rst deasserts.

Structure
REQ-029 State encoding type and default CLKS_PER_BIT constant SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-030 FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH=8, DEPTH_LOG2), with push/pop/full/empty/count.
REQ-031 No combinational path from UART_RX to any output.

Verification (bench uses CLKS_PER_BIT=16, DEPTH_LOG2=4)
REQ-032 Send 0xA5 with rx_ready=1 -> rx_valid pulses once with rx_data=0xA5, frame_err=0, rx_count returns to 0.
REQ-033 Drive UART_RX low 4 cycles then high -> no push, state back to IDLE, rx_valid stays 0.
REQ-034 Send 0x3C with stop bit low for 40 cycles -> frame_err=1, rx_count=0; then send 0x55 -> rx_data=0x55 received; err_clr -> frame_err=0.
REQ-035 rx_ready=0, send bytes 0x00..0x10 (17) -> rx_count=16, overrun=1, drained order 0x00..0x0F.
REQ-036 FIFO full, rx_ready=1 on the stop-sample cycle of byte 0x77 -> rx_count stays 16, overrun=0, 0x77 last out.
REQ-037 Assert rst during DATA bit 4 of 0xFF -> after release rx_count=0, no byte pushed; next frame 0x81 received correctly.
